// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the two-core data memory arbiter.
package dmem_arb_pkg;
  localparam int NUM_CORES = 2;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side handshake and data_mem-side bus of the arbiter.
interface dmem_arbiter_if #(
  parameter int n         = 32,
  parameter int dmem_size = 4
);
  import dmem_arb_pkg::*;

  logic [NUM_CORES-1:0]                core_req;
  logic [NUM_CORES-1:0]                core_we;
  logic [NUM_CORES-1:0][dmem_size-1:0] core_addr;
  logic [NUM_CORES-1:0][n-1:0]         core_wdata;
  logic [NUM_CORES-1:0]                core_ack;
  logic [n-1:0]                        core_rdata;
  logic [dmem_size-1:0]                dmem_address;
  logic [n-1:0]                        dmem_wdata;
  logic                                load_control;
  logic                                store_control;
  logic [n-1:0]                        dmem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, dmem_rdata,
    output core_ack, core_rdata, dmem_address, dmem_wdata,
           load_control, store_control
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, dmem_rdata,
    input  core_ack, core_rdata, dmem_address, dmem_wdata,
           load_control, store_control
  );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the core
// that was not granted last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_grant;
      default: gnt_id = 1'b0;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-core front end for data_mem: round-robin grant, one access per
// IDLE/ACCESS/RESP pass, registered read data returned with a one-cycle ack.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int n         = 32,
  parameter int dmem_size = 4
) (
  input  logic          clk,
  input  logic          nReset,
  dmem_arbiter_if.slave bus
);
  typedef struct packed {
    logic                 id;
    logic                 we;
    logic [dmem_size-1:0] addr;
    logic [n-1:0]         wdata;
  } hold_t;

  arb_state_t   state_q, state_d;
  hold_t        hold_q;
  logic [n-1:0] rdata_q;
  logic         last_grant;
  logic         gnt_valid, gnt_id;
  logic         ack_en;

  rr_arbiter2 u_rr (
    .req        (bus.core_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      hold_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_valid)
        hold_q <= '{id:    gnt_id,
                    we:    bus.core_we[gnt_id],
                    addr:  bus.core_addr[gnt_id],
                    wdata: bus.core_wdata[gnt_id]};
      if (state_q == ACCESS && !hold_q.we)
        rdata_q <= bus.dmem_rdata;
      if (state_q == RESP)
        last_grant <= hold_q.id;
    end
  end

  // Strobes and ack are gated by nReset so an aborted access never writes
  // memory or signals completion on the reset edge.
  assign bus.dmem_address  = hold_q.addr;
  assign bus.dmem_wdata    = hold_q.wdata;
  assign bus.load_control  = nReset && (state_q == ACCESS) && !hold_q.we;
  assign bus.store_control = nReset && (state_q == ACCESS) &&  hold_q.we;
  assign bus.core_rdata    = rdata_q;
  assign ack_en            = nReset && (state_q == RESP);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_ack
    assign bus.core_ack[i] = ack_en && (hold_q.id == 1'(i));
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural data_mem model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  typedef struct {
    int          id;
    bit          load;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.n(32), .dmem_size(4)) bus();
  dmem_arbiter #(.n(32), .dmem_size(4)) dut (.clk(clk), .nReset(nReset), .bus(bus));

  logic [31:0] mem [16] = '{default: '0};
  always @(posedge clk) if (bus.store_control) mem[bus.dmem_address] <= bus.dmem_wdata;
  assign bus.dmem_rdata = mem[bus.dmem_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_pass = 0, n_total = 0;
  int   st_cnt = 0, ack_cnt = 0;
  exp_t sb[$];
  exp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard on every ack seen at the falling edge.
  always @(negedge clk) begin
    if (bus.store_control) st_cnt++;
    if (bus.core_ack != 2'b00) begin
      ack_cnt++;
      chk("ack_onehot", 32'(bus.core_ack != 2'b11), 32'd1);
      if (sb.size() == 0) chk("unexpected_ack", 32'(bus.core_ack), 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_id", 32'(bus.core_ack), 32'(2'b01 << e.id));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        if (e.load) chk("rdata", bus.core_rdata, e.rdata);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input int c);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (bus.core_ack[c]) seen = 1'b1;
    end
    if (!seen) chk($sformatf("ack_timeout_core%0d", c), 32'd0, 32'd1);
  endtask

  task automatic single(input int c, input bit we, input logic [3:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    tick();
    bus.core_req[c]   = 1'b1;
    bus.core_we[c]    = we;
    bus.core_addr[c]  = a;
    bus.core_wdata[c] = wd;
    sb.push_back('{id: c, load: !we, rdata: exp_rd, cyc: cyc + 2});
    wait_ack(c);
    bus.core_req[c] = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"},   32'(bus.core_ack),      32'd0);
    chk({tag, "_load"},  32'(bus.load_control),  32'd0);
    chk({tag, "_store"}, 32'(bus.store_control), 32'd0);
    chk({tag, "_addr"},  32'(bus.dmem_address),  32'd0);
    chk({tag, "_wdata"}, bus.dmem_wdata,         32'd0);
    chk({tag, "_rdata"}, bus.core_rdata,         32'd0);
  endtask

  initial begin
    int c0, s0, a0;
    bus.core_req   = 2'b11;
    bus.core_we    = 2'b00;
    bus.core_addr  = '0;
    bus.core_wdata = '0;

    // Reset held two edges with both cores requesting, then core 0 wins the tie
    tick();
    tick();
    chk_idle_outputs("rst");
    chk("rst_no_ack", 32'(ack_cnt), 32'd0);
    nReset = 1'b1;
    sb.push_back('{id: 0, load: 1'b1, rdata: 32'd0, cyc: cyc + 2});
    wait_ack(0);
    bus.core_req = 2'b00;

    // Store then load on core 0
    s0 = st_cnt;
    single(0, 1'b1, 4'h5, 32'hDEADBEEF, 32'd0);
    chk("store_once", 32'(st_cnt - s0), 32'd1);
    chk("mem5", mem[5], 32'hDEADBEEF);
    single(0, 1'b0, 4'h5, 32'd0, 32'hDEADBEEF);

    // Cross-core coherence
    single(1, 1'b1, 4'hF, 32'h0000_00A5, 32'd0);
    single(0, 1'b0, 4'hF, 32'd0, 32'h0000_00A5);

    // Core 1 request raised during core 0 ACCESS waits for the next IDLE
    tick();
    c0 = cyc;
    bus.core_req[0] = 1'b1; bus.core_we[0] = 1'b0; bus.core_addr[0] = 4'h5;
    sb.push_back('{id: 0, load: 1'b1, rdata: 32'hDEADBEEF, cyc: c0 + 2});
    tick();
    chk("mid_access_load", 32'(bus.load_control), 32'd1);
    bus.core_req[1] = 1'b1; bus.core_we[1] = 1'b0; bus.core_addr[1] = 4'hF;
    sb.push_back('{id: 1, load: 1'b1, rdata: 32'h0000_00A5, cyc: c0 + 5});
    wait_ack(0);
    bus.core_req[0] = 1'b0;
    wait_ack(1);
    bus.core_req[1] = 1'b0;

    // Continuous tie: grants alternate 0,1,0,1 every 3 cycles
    tick();
    c0 = cyc;
    bus.core_req = 2'b11; bus.core_we = 2'b00;
    bus.core_addr[0] = 4'h5; bus.core_addr[1] = 4'hF;
    sb.push_back('{id: 0, load: 1'b1, rdata: 32'hDEADBEEF,   cyc: c0 + 2});
    sb.push_back('{id: 1, load: 1'b1, rdata: 32'h0000_00A5,  cyc: c0 + 5});
    sb.push_back('{id: 0, load: 1'b1, rdata: 32'hDEADBEEF,   cyc: c0 + 8});
    sb.push_back('{id: 1, load: 1'b1, rdata: 32'h0000_00A5,  cyc: c0 + 11});
    wait_ack(0);
    wait_ack(1);
    wait_ack(0);
    wait_ack(1);
    bus.core_req = 2'b00;

    // Reset asserted during a store's ACCESS: no write, no ack
    a0 = ack_cnt;
    tick();
    bus.core_req[0] = 1'b1; bus.core_we[0] = 1'b1;
    bus.core_addr[0] = 4'h2; bus.core_wdata[0] = 32'h0000_1234;
    tick();
    chk("pre_rst_store", 32'(bus.store_control), 32'd1);
    nReset = 1'b0;
    bus.core_req = 2'b00;
    #1;
    chk("rst_gate_store", 32'(bus.store_control), 32'd0);
    chk("rst_gate_load",  32'(bus.load_control),  32'd0);
    tick();
    tick();
    chk_idle_outputs("rst2");
    nReset = 1'b1;
    repeat (5) tick();
    chk("mem2_unchanged", mem[2], 32'd0);
    chk("no_abort_ack", 32'(ack_cnt - a0), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
